// File: rtl/hamming_pkg.sv
// hamming_pkg: shared FSM state, correction flags and SECDED helper functions
// for the memory-walking Hamming engine.
package hamming_pkg;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CALC, WR_LO, WR_HI, DONE} state_t;

    localparam logic [1:0] F_OK  = 2'b00;
    localparam logic [1:0] F_SGL = 2'b01;
    localparam logic [1:0] F_DBL = 2'b10;

    // Codeword bit k holds Hamming position k; bit 0 carries the overall parity p16.
    function automatic logic [15:0] ham_encode(input logic [11:1] d);
        logic p8, p4, p2, p1;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, (^d) ^ p8 ^ p4 ^ p2 ^ p1};
    endfunction

    function automatic logic [3:0] ham_syndrome(input logic [15:0] cw);
        logic [3:0] s;
        s = '0;
        for (int k = 1; k < 16; k++)
            if (cw[k]) s ^= 4'(k);
        return s;
    endfunction

endpackage

// File: rtl/hamming_codec.sv
// hamming_codec: combinational SECDED encode (mode 0) or decode/correct (mode 1)
// of one 16-bit word assembled from two memory bytes.
module hamming_codec
    import hamming_pkg::*;
(
    input  logic        i_mode,
    input  logic [15:0] i_cw,
    output logic [15:0] o_res
);

    logic [3:0]  w_s;
    logic        w_p;
    logic [15:0] w_fix;
    logic [1:0]  w_f;

    assign w_s = ham_syndrome(i_cw);
    assign w_p = ^i_cw;
    // Position 0 is masked so a syndrome of zero (p16 error) leaves the data alone.
    assign w_fix = i_cw ^ (w_p ? ((16'd1 << w_s) & 16'hFFFE) : 16'd0);
    assign w_f = w_p ? F_SGL : (w_s != 4'd0 ? F_DBL : F_OK);
    assign o_res = i_mode ? {w_f, 3'b000, w_fix[15:9], w_fix[7:5], w_fix[3]}
                          : ham_encode(i_cw[10:0]);

endmodule

// File: rtl/hamming_mem_engine.sv
// hamming_mem_engine: on a req edge walks NWORDS words through data memory,
// encoding or decoding each and writing the 16-bit results back, then pulses ack.
module hamming_mem_engine
    import hamming_pkg::*;
#(
    parameter int AW      = 8,
    parameter int NWORDS  = 15,
    parameter int ENC_SRC = 0,
    parameter int ENC_DST = 30,
    parameter int DEC_SRC = 64,
    parameter int DEC_DST = 94
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          mode,
    output logic          ack,
    output logic [AW-1:0] dm_addr,
    input  logic [7:0]    dm_rd_data,
    output logic          dm_wr_en,
    output logic [7:0]    dm_wr_data
);

    state_t        r_state, w_next;
    logic          r_req_q, r_mode;
    logic [AW-1:0] r_i, r_addr;
    logic [7:0]    r_lo, r_hi;
    logic [15:0]   r_res, w_res;
    logic [AW-1:0] w_src, w_dst, w_off;

    assign w_src = r_mode ? AW'(DEC_SRC) : AW'(ENC_SRC);
    assign w_dst = r_mode ? AW'(DEC_DST) : AW'(ENC_DST);
    assign w_off = r_i << 1;

    hamming_codec u_codec (
        .i_mode (r_mode),
        .i_cw   ({r_hi, r_lo}),
        .o_res  (w_res)
    );

    // The address is re-driven from r_addr in non-access states so it holds its last value.
    always_comb begin
        w_next     = r_state;
        ack        = 1'b0;
        dm_wr_en   = 1'b0;
        dm_wr_data = '0;
        dm_addr    = r_addr;
        case (r_state)
            IDLE:  w_next = (req && !r_req_q) ? RD_LO : IDLE;
            RD_LO: begin
                dm_addr = w_src + w_off;
                w_next  = RD_HI;
            end
            RD_HI: begin
                dm_addr = w_src + w_off + AW'(1);
                w_next  = CALC;
            end
            CALC:  w_next = WR_LO;
            WR_LO: begin
                dm_addr    = w_dst + w_off;
                dm_wr_en   = 1'b1;
                dm_wr_data = r_res[7:0];
                w_next     = WR_HI;
            end
            WR_HI: begin
                dm_addr    = w_dst + w_off + AW'(1);
                dm_wr_en   = 1'b1;
                dm_wr_data = r_res[15:8];
                w_next     = (r_i == AW'(NWORDS - 1)) ? DONE : RD_LO;
            end
            DONE: begin
                ack    = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_req_q <= 1'b0;
            r_mode  <= 1'b0;
            r_i     <= '0;
            r_addr  <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_next;
            r_req_q <= req;
            r_addr  <= dm_addr;
            if (r_state == IDLE && w_next == RD_LO) begin
                r_mode <= mode;
                r_i    <= '0;
            end
            if (r_state == RD_LO) r_lo <= dm_rd_data;
            if (r_state == RD_HI) r_hi <= dm_rd_data;
            if (r_state == CALC) r_res <= w_res;
            if (r_state == WR_HI && w_next == RD_LO) r_i <= r_i + AW'(1);
        end
    end

endmodule

// File: tb/tb_hamming_mem_engine.sv
// tb_hamming_mem_engine: scoreboard bench with a bench-side memory and an
// independent positional Hamming model.
module tb_hamming_mem_engine;

    logic       clk = 1'b0;
    logic       reset, req, mode, ack, dm_wr_en;
    logic [7:0] dm_addr, dm_rd_data, dm_wr_data;
    logic       tb_we;
    logic [7:0] tb_wa, tb_wd;
    logic [7:0] mem [256];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    int pass_cnt = 0, chk_cnt = 0, bad_wr = 0, cur_dst = 30;
    logic [7:0] dec_k [8] = '{8'hFF, 8'h47, 8'hFF, 8'h47, 8'hFF, 8'h87, 8'h00, 8'h00};

    always #5 clk = ~clk;

    hamming_mem_engine dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .mode       (mode),
        .ack        (ack),
        .dm_addr    (dm_addr),
        .dm_rd_data (dm_rd_data),
        .dm_wr_en   (dm_wr_en),
        .dm_wr_data (dm_wr_data)
    );

    assign dm_rd_data = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_wr_en) mem[dm_addr] <= dm_wr_data;
        else if (tb_we) mem[tb_wa] <= tb_wd;
    end

    always @(negedge clk) begin
        if (dm_wr_en) begin
            obs_q.push_back({dm_addr, dm_wr_data});
            if (int'(dm_addr) < cur_dst || int'(dm_addr) > cur_dst + 29) bad_wr++;
        end
    end

    // Data bits fill the non-power-of-two positions; parity j covers positions with bit j set.
    function automatic logic [15:0] m_enc(input logic [10:0] d);
        logic [15:0] c;
        int j;
        c = '0;
        j = 0;
        for (int k = 1; k < 16; k++)
            if ((k & (k - 1)) != 0) begin
                c[k] = d[j];
                j++;
            end
        for (int b = 0; b < 4; b++)
            for (int k = 1; k < 16; k++)
                if (((k >> b) & 1) == 1 && k != (1 << b)) c[1 << b] ^= c[k];
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [15:0] m_dec(input logic [15:0] cw);
        logic [15:0] c;
        logic [10:0] d;
        logic [1:0]  f;
        int s, j;
        c = cw;
        s = 0;
        for (int k = 1; k < 16; k++) if (c[k]) s ^= k;
        if (^cw && s != 0) c[s] = ~c[s];
        f = (^cw) ? 2'b01 : (s != 0 ? 2'b10 : 2'b00);
        j = 0;
        for (int k = 1; k < 16; k++)
            if ((k & (k - 1)) != 0) begin
                d[j] = c[k];
                j++;
            end
        return {f, 3'b000, d};
    endfunction

    task automatic load(input int a, input logic [15:0] v);
        tb_we = 1'b1;
        tb_wa = 8'(a);
        tb_wd = v[7:0];
        @(posedge clk); #1;
        tb_wa = 8'(a + 1);
        tb_wd = v[15:8];
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic push_exp(input int a, input logic [15:0] r);
        exp_q.push_back({8'(a), r[7:0]});
        exp_q.push_back({8'(a + 1), r[15:8]});
    endtask

    // Pulses req (E0), then watches 100 cycles; mode is flipped mid-run on purpose.
    task automatic run_op(input logic m, input int req2_at, input int rst_at,
                          output int ack_cyc, output int ack_n, output logic rst_wr);
        ack_cyc = 0;
        ack_n = 0;
        rst_wr = 1'b1;
        @(posedge clk); #1;
        req = 1'b1;
        mode = m;
        @(posedge clk); #1;
        req = 1'b0;
        mode = ~m;
        for (int k = 1; k <= 100; k++) begin
            if (ack) begin
                ack_n++;
                if (ack_cyc == 0) ack_cyc = k;
            end
            req = (k == req2_at);
            if (k == rst_at) reset = 1'b1;
            if (k == rst_at + 1) begin
                rst_wr = dm_wr_en;
                reset = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic score(input string nm);
        logic [15:0] o, e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            chk_cnt++;
            if (exp_q.size() == 0) $display("FAIL %s_extra: wrote %h, required no write", nm, o);
            else begin
                e = exp_q.pop_front();
                if (o !== e) $display("FAIL %s_wr: got %h, required %h", nm, o, e);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s_missing: %0d writes left, required 0", nm, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic check_ack(input string nm, input int ack_cyc, input int ack_n);
        chk_cnt++;
        if (ack_cyc !== 76) $display("FAIL %s_ack_cycle: got %0d, required 76", nm, ack_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (ack_n !== 1) $display("FAIL %s_ack_width: got %0d, required 1", nm, ack_n);
        else pass_cnt++;
    endtask

    task automatic load_enc_random();
        logic [10:0] d;
        logic [4:0]  g;
        for (int w = 0; w < 15; w++) begin
            d = 11'($urandom_range(0, 2047));
            g = 5'($urandom_range(0, 31));
            load(2 * w, {g, d});
            push_exp(30 + 2 * w, m_enc(d));
        end
    endtask

    task automatic load_dec_random(input int first);
        logic [15:0] cw;
        for (int w = first; w < 15; w++) begin
            cw = m_enc(11'($urandom_range(0, 2047))) ^ (16'd1 << $urandom_range(0, 15));
            load(64 + 2 * w, cw);
            push_exp(94 + 2 * w, m_dec(cw));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt += 4;
        if (ack !== 1'b0) $display("FAIL rst_ack: got %b, required 0", ack); else pass_cnt++;
        if (dm_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b, required 0", dm_wr_en); else pass_cnt++;
        if (dm_addr !== 8'h00) $display("FAIL rst_addr: got %h, required 00", dm_addr); else pass_cnt++;
        if (dm_wr_data !== 8'h00) $display("FAIL rst_wr_data: got %h, required 00", dm_wr_data); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_encode();
        int ac, an;
        logic rw;
        logic [7:0] ek [4];
        ek = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        cur_dst = 30;
        load_enc_random();
        exp_q.delete();
        load(0, 16'h0000);
        load(2, 16'hFFFF);
        for (int w = 0; w < 15; w++) push_exp(30 + 2 * w, m_enc(w == 0 ? 11'h000 : w == 1 ? 11'h7FF : 11'(mem[2 * w]) | (11'(mem[2 * w + 1][2:0]) << 8)));
        run_op(1'b0, -5, -5, ac, an, rw);
        check_ack("enc", ac, an);
        score("enc");
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (mem[30 + i] !== ek[i]) $display("FAIL enc_mem%0d: got %h, required %h", 30 + i, mem[30 + i], ek[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_decode();
        int ac, an;
        logic rw;
        logic [15:0] dk [4];
        dk = '{16'hFFDF, 16'hFFFE, 16'hFFFC, 16'h0000};
        cur_dst = 94;
        for (int w = 0; w < 4; w++) begin
            load(64 + 2 * w, dk[w]);
            push_exp(94 + 2 * w, m_dec(dk[w]));
        end
        load_dec_random(4);
        run_op(1'b1, -5, -5, ac, an, rw);
        check_ack("dec", ac, an);
        score("dec");
        for (int i = 0; i < 8; i++) begin
            chk_cnt++;
            if (mem[94 + i] !== dec_k[i]) $display("FAIL dec_mem%0d: got %h, required %h", 94 + i, mem[94 + i], dec_k[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_timing();
        int ac, an;
        logic rw;
        cur_dst = 30;
        load_enc_random();
        run_op(1'b0, 20, -5, ac, an, rw);
        check_ack("req2", ac, an);
        score("req2");
    endtask

    task automatic test_reset_mid();
        int ac, an;
        logic rw;
        cur_dst = 30;
        load_enc_random();
        exp_q.delete();
        run_op(1'b0, -5, 30, ac, an, rw);
        obs_q.delete();
        chk_cnt += 2;
        if (an !== 0) $display("FAIL midrst_ack: got %0d pulses, required 0", an); else pass_cnt++;
        if (rw !== 1'b0) $display("FAIL midrst_wr_en: got %b, required 0", rw); else pass_cnt++;
        load_enc_random();
        run_op(1'b0, -5, -5, ac, an, rw);
        check_ack("after_rst", ac, an);
        score("after_rst");
    endtask

    task automatic test_random();
        int ac, an, b0;
        logic rw;
        b0 = bad_wr;
        cur_dst = 30;
        load_enc_random();
        run_op(1'b0, -5, -5, ac, an, rw);
        check_ack("rnd_enc", ac, an);
        score("rnd_enc");
        cur_dst = 94;
        load_dec_random(0);
        run_op(1'b1, -5, -5, ac, an, rw);
        check_ack("rnd_dec", ac, an);
        score("rnd_dec");
        chk_cnt++;
        if (bad_wr !== b0) $display("FAIL wr_range: got %0d stray writes, required 0", bad_wr - b0);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        req = 1'b0;
        mode = 1'b0;
        tb_we = 1'b0;
        tb_wa = '0;
        tb_wd = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_encode();
        test_decode();
        test_timing();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
